spi_frame_rx: RTL and testbench

- Synchronous SPI slave front-end for the expander CPLD, clocked from the Pentagon 14 MHz clock.
- Receives configuration, Kempston mouse, Kempston joystick and keyboard frames from the MCU over SPI2.
- Validates frame length and commits each frame atomically into the holding registers that the Z80 port decoders read (#FE, #FADF/#FBDF/#FFDF, #1F, config).
- Replaces free-running SCK-clocked shift registers, so there are no partially shifted values visible to the Z80 bus.

---
 rtl/spi_frame_rx_if.sv | 27 ++
 rtl/spi_frame_rx.sv | 170 +++++++++++++++++
 tb/tb_spi_frame_rx.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_if.sv
// SPI frame receiver bus: MCU-side SPI lines plus the committed holding
// registers and strobes seen by the Z80 port decoders.
interface spi_frame_rx_if #(
    parameter int ERR_W = 8
);
    logic             SPI_SCK;
    logic             SPI_NSS;
    logic             SPI_MOSI;
    logic [1:0]       SPI_A;
    logic [7:0]       CFG;
    logic [23:0]      MOUSE;
    logic [7:0]       KMPST;
    logic [39:0]      KBD;
    logic [3:0]       UPD;
    logic [ERR_W-1:0] ERR_CNT;
    logic             BUSY;

    modport master (
        output SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A,
        input  CFG, MOUSE, KMPST, KBD, UPD, ERR_CNT, BUSY
    );

    modport slave (
        input  SPI_SCK, SPI_NSS, SPI_MOSI, SPI_A,
        output CFG, MOUSE, KMPST, KBD, UPD, ERR_CNT, BUSY
    );
endinterface

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI slave front-end sampled entirely in the CLK14M domain.
// Frames are shifted into a shadow register and committed atomically to the
// holding registers only when the frame length (and optional CRC) checks out.
// Optional feature: define SPI_FRAME_CRC_EN to require a trailing CRC-8
// (poly 0x07, init 0x00, MSB first) on every frame.
module spi_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = 8
) (
    input logic           CLK14M,
    input logic           RST_N,
    spi_frame_rx_if.slave bus
);
`ifdef SPI_FRAME_CRC_EN
    localparam int CRC_W = 8;
`else
    localparam int CRC_W = 0;
`endif
    localparam int SH_W = 40 + CRC_W;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [SYNC_STAGES-1:0]      sck_sync, nss_sync, mosi_sync;
    logic [SYNC_STAGES-1:0][1:0] a_sync;
    logic                        sck_q, nss_q;
    logic                        sck_rise, nss_fall, nss_rise, mosi_bit;
    logic [1:0]                  a_cur;

    state_t           state;
    logic [1:0]       tgt;
    logic [SH_W-1:0]  shadow;
    logic [5:0]       bit_cnt;
    logic [5:0]       exp_len;
    logic             frame_ok;
    logic [7:0]       cfg, kmpst;
    logic [23:0]      mouse;
    logic [39:0]      kbd;
    logic [3:0]       upd;
    logic [ERR_W-1:0] err_cnt;
    logic             busy;

    function automatic logic [5:0] payload_len(input logic [1:0] t);
        case (t)
            2'b00:   return 6'd8;
            2'b01:   return 6'd24;
            2'b10:   return 6'd8;
            default: return 6'd40;
        endcase
    endfunction

`ifdef SPI_FRAME_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Synchronise the async SPI lines and keep one extra sample for edge detection.
    // NSS resets to "low" so a reset inside a frame cannot manufacture a fresh fall.
    always_ff @(posedge CLK14M) begin
        if (!RST_N) begin
            sck_sync  <= '0;
            nss_sync  <= '0;
            mosi_sync <= '0;
            a_sync    <= '0;
            sck_q     <= 1'b0;
            nss_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.SPI_SCK};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], bus.SPI_NSS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_MOSI};
            a_sync    <= {a_sync[SYNC_STAGES-2:0], bus.SPI_A};
            sck_q     <= sck_sync[SYNC_STAGES-1];
            nss_q     <= nss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_q;
    assign nss_fall = ~nss_sync[SYNC_STAGES-1] & nss_q;
    assign nss_rise = nss_sync[SYNC_STAGES-1] & ~nss_q;
    assign mosi_bit = mosi_sync[SYNC_STAGES-1];
    assign a_cur    = a_sync[SYNC_STAGES-1];

    assign exp_len = payload_len(tgt) + 6'(CRC_W);
`ifdef SPI_FRAME_CRC_EN
    assign frame_ok = (bit_cnt == exp_len) && (shadow[7:0] == crc);
`else
    assign frame_ok = (bit_cnt == exp_len);
`endif

    // Frame FSM: capture target on NSS fall, shift on SCK rise, validate and commit after NSS rise.
    always_ff @(posedge CLK14M) begin
        if (!RST_N) begin
            state   <= IDLE;
            tgt     <= 2'b00;
            shadow  <= '0;
            bit_cnt <= '0;
`ifdef SPI_FRAME_CRC_EN
            crc     <= 8'h00;
`endif
            cfg     <= 8'h00;
            mouse   <= 24'h0000FF;
            kmpst   <= 8'h00;
            kbd     <= 40'hFF_FFFF_FFFF;
            upd     <= 4'b0000;
            err_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            upd <= 4'b0000;
            case (state)
                IDLE: begin
                    if (nss_fall) begin
                        tgt     <= a_cur;
                        shadow  <= '0;
                        bit_cnt <= '0;
`ifdef SPI_FRAME_CRC_EN
                        crc     <= 8'h00;
`endif
                        state   <= RECV;
                        busy    <= 1'b1;
                    end
                end
                RECV: begin
                    // A shift coincident with NSS rise still lands before CHECK.
                    if (sck_rise) begin
                        shadow <= {shadow[SH_W-2:0], mosi_bit};
                        if (bit_cnt != 6'd63)
                            bit_cnt <= bit_cnt + 6'd1;
`ifdef SPI_FRAME_CRC_EN
                        if (bit_cnt < payload_len(tgt))
                            crc <= crc_step(crc, mosi_bit);
`endif
                    end
                    if (nss_rise)
                        state <= CHECK;
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (frame_ok) begin
                        upd[tgt] <= 1'b1;
                        case (tgt)
                            2'b00:   cfg   <= shadow[CRC_W +: 8];
                            2'b01:   mouse <= shadow[CRC_W +: 24];
                            2'b10:   kmpst <= shadow[CRC_W +: 8];
                            default: kbd   <= shadow[CRC_W +: 40];
                        endcase
                    end else if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CFG     = cfg;
    assign bus.MOUSE   = mouse;
    assign bus.KMPST   = kmpst;
    assign bus.KBD     = kbd;
    assign bus.UPD     = upd;
    assign bus.ERR_CNT = err_cnt;
    assign bus.BUSY    = busy;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Testbench for spi_frame_rx: randomized SPI frames against a frame-level
// reference model (length table, CRC-8 over the payload, saturating errors).
`timescale 1ns/1ps
module tb_spi_frame_rx;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_W       = 8;
`ifdef SPI_FRAME_CRC_EN
    localparam int CRC_W = 8;
`else
    localparam int CRC_W = 0;
`endif

    logic CLK14M = 1'b0;
    logic RST_N  = 1'b0;

    spi_frame_rx_if #(.ERR_W(ERR_W)) bus ();

    spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .ERR_W(ERR_W)) dut (
        .CLK14M(CLK14M),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #35 CLK14M = ~CLK14M;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0]  m_cfg, m_kmpst;
    logic [23:0] m_mouse;
    logic [39:0] m_kbd;
    int          m_err;

    bit fq[$];   // bits of the next frame, in transmission order

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK14M);
    endtask

    function automatic int plen(input logic [1:0] t);
        case (t)
            2'b00:   return 8;
            2'b01:   return 24;
            2'b10:   return 8;
            default: return 40;
        endcase
    endfunction

    function automatic logic [7:0] crc8_q(input int len);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < len; i++) begin
            fb = c[7] ^ fq[i];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fq.push_back(v[i]);
    endtask

    // append the checksum trailer when the build expects one
    task automatic seal(input int len);
        if (CRC_W != 0) push_bits({56'h0, crc8_q(len)}, 8);
    endtask

    task automatic model_reset();
        m_cfg   = 8'h00;
        m_mouse = 24'h0000FF;
        m_kmpst = 8'h00;
        m_kbd   = 40'hFF_FFFF_FFFF;
        m_err   = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".cfg"},   {56'h0, bus.CFG},     {56'h0, m_cfg});
        chk({tag, ".mouse"}, {40'h0, bus.MOUSE},   {40'h0, m_mouse});
        chk({tag, ".kmpst"}, {56'h0, bus.KMPST},   {56'h0, m_kmpst});
        chk({tag, ".kbd"},   {24'h0, bus.KBD},     {24'h0, m_kbd});
        chk({tag, ".err"},   {56'h0, bus.ERR_CNT}, 64'(m_err));
        chk({tag, ".busy"},  {63'h0, bus.BUSY},    64'h0);
    endtask

    // Decide a frame's fate from the rules: exact length, optional CRC trailer.
    task automatic model_frame(input logic [1:0] t, output bit ok, output logic [39:0] val);
        int len;
        logic [7:0] rx;
        len = plen(t);
        val = '0;
        ok  = (fq.size() == len + CRC_W);
        if (ok && CRC_W != 0) begin
            rx = '0;
            for (int i = 0; i < 8; i++) rx = {rx[6:0], fq[len + i]};
            ok = (rx == crc8_q(len));
        end
        if (ok)
            for (int i = 0; i < len; i++) val = {val[38:0], fq[i]};
    endtask

    // Send fq as one frame, then watch UPD for the commit window and compare.
    task automatic send_frame(input logic [1:0] t, input int half, input int tog_at, input bit same_edge);
        bit          ok;
        logic [39:0] val;
        logic [3:0]  upd_or, exp_upd;
        int          first_k, hi, n;
        model_frame(t, ok, val);
        n = fq.size();
        @(negedge CLK14M);
        bus.SPI_A   = t;
        bus.SPI_SCK = 1'b0;
        wait_clk(4);
        bus.SPI_NSS = 1'b0;
        wait_clk(half);
        chk("busy_in_frame", {63'h0, bus.BUSY}, 64'h1);
        for (int i = 0; i < n; i++) begin
            bus.SPI_SCK  = 1'b0;
            bus.SPI_MOSI = fq[i];
            if (i == tog_at) bus.SPI_A = ~t;
            wait_clk(half);
            bus.SPI_SCK = 1'b1;
            if (!(same_edge && i == n - 1)) wait_clk(half);
        end
        if (!(same_edge && n > 0)) begin
            bus.SPI_SCK = 1'b0;
            wait_clk(half);
        end
        bus.SPI_NSS = 1'b1;
        first_k = 0;
        hi      = 0;
        upd_or  = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK14M);
            #1;
            if (bus.UPD != 4'b0000) begin
                if (first_k == 0) first_k = k;
                hi++;
                upd_or |= bus.UPD;
            end
        end
        bus.SPI_SCK = 1'b0;
        exp_upd = '0;
        if (ok) begin
            exp_upd[t] = 1'b1;
            case (t)
                2'b00:   m_cfg   = val[7:0];
                2'b01:   m_mouse = val[23:0];
                2'b10:   m_kmpst = val[7:0];
                default: m_kbd   = val;
            endcase
        end else if (m_err < (1 << ERR_W) - 1) begin
            m_err++;
        end
        chk("upd", {60'h0, upd_or}, {60'h0, exp_upd});
        if (ok) begin
            chk("upd_latency", 64'(first_k), 64'(SYNC_STAGES + 2));
            chk("upd_width",   64'(hi), 64'h1);
        end
        @(negedge CLK14M);
        check_regs("frame");
        fq.delete();
    endtask

    initial begin
        #6_300_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  t;
        logic [63:0] rv;
        int          mode, n;
        bus.SPI_SCK  = 1'b0;
        bus.SPI_NSS  = 1'b1;
        bus.SPI_MOSI = 1'b0;
        bus.SPI_A    = 2'b00;
        RST_N        = 1'b0;
        model_reset();
        wait_clk(3);
        check_regs("reset");
        chk("reset.upd", {60'h0, bus.UPD}, 64'h0);
        RST_N = 1'b1;
        wait_clk(6);

        // keyboard frame at ~1 MHz SCK
        push_bits(64'hFE_FFFF_FF7F, 40); seal(40);
        send_frame(2'b11, 7, -1, 1'b0);
        chk("kbd", {24'h0, bus.KBD}, 64'hFE_FFFF_FF7F);

        // mouse frame with SPI_A flipped mid-frame
        push_bits(64'h1234FE, 24); seal(24);
        send_frame(2'b01, 7, 10, 1'b0);
        chk("mouse", {40'h0, bus.MOUSE}, 64'h1234FE);
        chk("mouse.cfg", {56'h0, bus.CFG}, 64'h0);

        // short and long config frames
        push_bits(64'h55, 7);
        send_frame(2'b00, 4, -1, 1'b0);
        push_bits(64'h1AA, 9);
        send_frame(2'b00, 4, -1, 1'b0);
        chk("len_err.cfg", {56'h0, bus.CFG}, 64'h0);
        chk("len_err.cnt", {56'h0, bus.ERR_CNT}, 64'h2);

        // randomized frames: good, wrong length, random trailer
        for (int f = 0; f < 30; f++) begin
            t    = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 3);
            rv   = {$urandom, $urandom};
            if (mode <= 1) begin
                push_bits(rv, plen(t)); seal(plen(t));
            end else if (mode == 2) begin
                n = plen(t) + CRC_W + ($urandom_range(0, 1) ? 1 : -1) * $urandom_range(1, 3);
                push_bits(rv, n);
            end else begin
                push_bits(rv, plen(t)); push_bits({56'h0, 8'($urandom)}, 8);
            end
            send_frame(t, $urandom_range(3, 6), $urandom_range(0, 40), 1'($urandom_range(0, 1)));
        end

        // zero-length frames drive the error counter into saturation
        repeat (260) send_frame(2'b00, 3, -1, 1'b0);
        chk("err_sat", {56'h0, bus.ERR_CNT}, 64'hFF);

        // last SCK rise coincident with NSS rise
        push_bits(64'h1F, 8); seal(8);
        send_frame(2'b10, 7, -1, 1'b1);
        chk("kmpst_edge", {56'h0, bus.KMPST}, 64'h1F);

`ifdef SPI_FRAME_CRC_EN
        push_bits(64'h80, 8); push_bits(64'h89, 8);
        send_frame(2'b00, 5, -1, 1'b0);
        chk("crc_good.cfg", {56'h0, bus.CFG}, 64'h80);
        push_bits(64'h40, 8); push_bits(64'h88, 8);
        send_frame(2'b00, 5, -1, 1'b0);
        chk("crc_bad.cfg", {56'h0, bus.CFG}, 64'h80);
`endif

        // reset after 20 bits of a keyboard frame, remainder of frame ignored
        @(negedge CLK14M);
        bus.SPI_A = 2'b11;
        wait_clk(4);
        bus.SPI_NSS = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) begin
                RST_N = 1'b0;
                wait_clk(3);
                model_reset();
                check_regs("mid_reset");
                RST_N = 1'b1;
            end
            bus.SPI_SCK  = 1'b0;
            bus.SPI_MOSI = 1'($urandom_range(0, 1));
            wait_clk(5);
            bus.SPI_SCK = 1'b1;
            wait_clk(5);
        end
        bus.SPI_SCK = 1'b0;
        wait_clk(5);
        bus.SPI_NSS = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK14M);
            #1;
            if (bus.UPD != 4'b0000) n++;
        end
        chk("mid_reset.upd", 64'(n), 64'h0);
        chk("mid_reset.kbd", {24'h0, bus.KBD}, 64'hFF_FFFF_FFFF);
        @(negedge CLK14M);
        check_regs("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
